vm_txn_controller: RTL and testbench

//  Transaction sequencer for a 4-product vending machine, built on the 5/10/20 tk coin encoding.

---
 rtl/vm_pkg.sv | 31 +++
 rtl/vm_change_engine.sv | 58 +++++
 rtl/vm_txn_controller.sv | 190 +++++++++++++++++++
 tb/tb_vm_txn_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine transaction controller.
//   - Coin acceptor codes (COIN_*), hopper change codes (CHG_*)
//   - Controller state encoding (state_t)
//   - coin_units(): coin code -> value in 5 tk units
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    localparam logic [1:0] CHG_5     = 2'b01;
    localparam logic [1:0] CHG_10    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    function automatic logic [2:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  coin_units = 3'd1;
            COIN_10: coin_units = 3'd2;
            COIN_20: coin_units = 3'd4;
            default: coin_units = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_engine.sv
// Change payout engine: pays the current credit back one coin at a time.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        1-cycle pulse on the edge that enters the change phase
//   credit       current credit (5 tk units), owned by the controller
//   chg_ack      hopper paid the requested coin (1-cycle pulse)
//   chg_req      change coin request, held until chg_ack
//   chg_coin     coin requested, stable while chg_req
//   dec          credit must drop by dec_units on this edge
//   dec_units    value of the coin just paid
//   done         last coin paid; credit reaches zero on this edge
module vm_change_engine
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                chg_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    output logic                dec,
    output logic [CREDIT_W-1:0] dec_units,
    output logic                done
);

    logic active;

    // An ack only counts while a request is outstanding.
    assign dec       = active && chg_req && chg_ack;
    assign dec_units = (chg_coin == CHG_10) ? CREDIT_W'(2) : CREDIT_W'(1);
    assign done      = dec && (credit == dec_units);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            chg_req  <= 1'b0;
            chg_coin <= 2'b00;
        end else begin
            if (start) begin
                active <= 1'b1;
            end else if (done) begin
                active <= 1'b0;
            end
            // Request drops on the ack edge and is re-raised one edge later,
            // after the controller has applied the decrement to credit.
            if (dec) begin
                chg_req <= 1'b0;
            end else if (active && !chg_req && credit != '0) begin
                chg_req  <= 1'b1;
                chg_coin <= (credit >= CREDIT_W'(2)) ? CHG_10 : CHG_5;
            end
        end
    end

endmodule

// File: rtl/vm_txn_controller.sv
// Transaction sequencer for a 4-product vending machine.
// Accumulates coin credit, validates selections, runs the dispenser
// handshake, then pays change through vm_change_engine.
// Handshakes: disp_req/chg_req are levels held until the matching 1-cycle
// ack; an ack with no request outstanding is ignored. All other outputs
// except busy/disp_req are 1-cycle registered pulses.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   coin_valid, coin_code    coin acceptor input
//   coin_accept, coin_reject coin outcome pulses
//   sel_valid, sel_id        product select
//   cancel                   refund request
//   sel_ack, sel_nack        selection outcome pulses
//   disp_req, disp_id, disp_ack   dispenser handshake
//   chg_req, chg_coin, chg_ack    hopper handshake
//   credit                   current credit, 5 tk units
//   busy                     dispensing or paying change
module vm_txn_controller
    import vm_pkg::*;
#(
    parameter int CREDIT_W    = 5,
    parameter int MAX_CREDIT  = 12,
    parameter int PRICE0      = 2,
    parameter int PRICE1      = 3,
    parameter int PRICE2      = 4,
    parameter int PRICE3      = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    output logic                coin_accept,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                sel_ack,
    output logic                sel_nack,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    input  logic                disp_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic [TIMER_W-1:0]  timer, timer_next;
    logic [1:0]          disp_id_next;
    logic                accept_next, reject_next, ack_next, nack_next;
    logic                chg_start;
    logic                coin_live, coin_fits, activity, cancel_hit;
    logic [CREDIT_W:0]   coin_sum;
    logic                chg_dec, chg_done;
    logic [CREDIT_W-1:0] chg_units, disp_left;

    assign coin_live  = coin_valid && (coin_code != COIN_NONE);
    assign coin_sum   = {1'b0, credit} + (CREDIT_W + 1)'(coin_units(coin_code));
    assign coin_fits  = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
    assign cancel_hit = (state == ST_CREDIT) && cancel;
    // Anything that restarts the inactivity timer.
    assign activity   = (coin_live && coin_fits) || sel_valid;
    assign disp_left  = credit - price_of(disp_id);

    always_comb begin
        state_next   = state;
        credit_next  = credit;
        timer_next   = timer;
        disp_id_next = disp_id;
        accept_next  = 1'b0;
        reject_next  = 1'b0;
        ack_next     = 1'b0;
        nack_next    = 1'b0;
        chg_start    = 1'b0;
        case (state)
            ST_IDLE, ST_CREDIT: begin
                if (coin_live) begin
                    if (coin_fits) begin
                        credit_next = coin_sum[CREDIT_W-1:0];
                        accept_next = 1'b1;
                        state_next  = ST_CREDIT;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
                // A coin or a cancel in the same cycle wins over a select.
                if (sel_valid) begin
                    if (coin_live || cancel_hit || credit < price_of(sel_id)) begin
                        nack_next = 1'b1;
                    end else begin
                        ack_next     = 1'b1;
                        disp_id_next = sel_id;
                        state_next   = ST_DISPENSE;
                    end
                end
                if (activity) begin
                    timer_next = '0;
                end else if (state == ST_CREDIT) begin
                    timer_next = timer + TIMER_W'(1);
                end
                // Cancel refunds credit_next, so a coin in the same cycle is included.
                if (cancel_hit || (state == ST_CREDIT && !activity &&
                                   timer == TIMER_W'(TIMEOUT_CYC - 1))) begin
                    state_next = ST_CHANGE;
                    chg_start  = 1'b1;
                    timer_next = '0;
                end
            end
            ST_DISPENSE: begin
                reject_next = coin_live;
                nack_next   = sel_valid;
                if (disp_ack) begin
                    credit_next = disp_left;
                    if (disp_left != '0) begin
                        state_next = ST_CHANGE;
                        chg_start  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                reject_next = coin_live;
                nack_next   = sel_valid;
                if (chg_dec) begin
                    credit_next = credit - chg_units;
                end
                if (chg_done) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            timer       <= '0;
            disp_id     <= 2'b00;
            coin_accept <= 1'b0;
            coin_reject <= 1'b0;
            sel_ack     <= 1'b0;
            sel_nack    <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            timer       <= timer_next;
            disp_id     <= disp_id_next;
            coin_accept <= accept_next;
            coin_reject <= reject_next;
            sel_ack     <= ack_next;
            sel_nack    <= nack_next;
        end
    end

    assign disp_req = (state == ST_DISPENSE);
    assign busy     = (state == ST_DISPENSE) || (state == ST_CHANGE);

    vm_change_engine #(
        .CREDIT_W(CREDIT_W)
    ) u_change (
        .clk      (clk),
        .reset    (reset),
        .start    (chg_start),
        .credit   (credit),
        .chg_ack  (chg_ack),
        .chg_req  (chg_req),
        .chg_coin (chg_coin),
        .dec      (chg_dec),
        .dec_units(chg_units),
        .done     (chg_done)
    );

endmodule

// File: tb/tb_vm_txn_controller.sv
module tb_vm_txn_controller;

    localparam int T_OUT  = 1000;
    localparam int MAXC   = 12;
    localparam int M_IDLE = 0, M_CREDIT = 1, M_DISP = 2, M_CHANGE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid, sel_valid, cancel, disp_ack, chg_ack;
    logic [1:0] coin_code, sel_id;
    logic       coin_accept, coin_reject, sel_ack, sel_nack;
    logic       disp_req, chg_req, busy;
    logic [1:0] disp_id, chg_coin;
    logic [4:0] credit;

    vm_txn_controller dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .coin_accept(coin_accept), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .sel_ack(sel_ack), .sel_nack(sel_nack),
        .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
        .credit(credit), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    int price[4] = '{2, 3, 4, 6};

    int         m_mode, m_credit, m_idle, m_disp_id;
    bit         m_req, m_pending;
    logic [1:0] m_coin;
    bit         e_acc, e_rej, e_ack, e_nack;
    logic [1:0] exp_q[$];   // change coins still owed, in payout order

    function automatic int coin_val(input logic [1:0] c);
        return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 4 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_disp_id = 0;
        m_req = 0; m_pending = 0; m_coin = 2'b00;
        e_acc = 0; e_rej = 0; e_ack = 0; e_nack = 0;
        exp_q.delete();
    endtask

    // Refund: largest coins first, so 10 tk while at least 10 tk is owed.
    task automatic start_refund();
        m_mode = M_CHANGE; m_idle = 0; m_req = 0; m_pending = 1;
        exp_q.delete();
        for (int k = 0; k < m_credit / 2; k++) exp_q.push_back(2'b10);
        if (m_credit % 2 == 1) exp_q.push_back(2'b01);
    endtask

    task automatic model_step(input bit cv, input logic [1:0] cc, input bit sv,
                              input logic [1:0] sid, input bit cn, input bit da, input bit ca);
        bit live, was_credit, act;
        live = cv && (cc != 2'b00);
        was_credit = (m_mode == M_CREDIT);
        e_acc = 0; e_rej = 0; e_ack = 0; e_nack = 0;
        if (m_mode == M_IDLE || m_mode == M_CREDIT) begin
            act = 0;
            if (live) begin
                if (m_credit + coin_val(cc) <= MAXC) begin
                    m_credit += coin_val(cc); e_acc = 1; m_mode = M_CREDIT; act = 1;
                end else e_rej = 1;
            end
            if (sv) begin
                act = 1;
                if (live || (was_credit && cn) || m_credit < price[sid]) e_nack = 1;
                else begin e_ack = 1; m_disp_id = sid; m_mode = M_DISP; end
            end
            if (act) m_idle = 0;
            if (was_credit && cn) start_refund();
            else if (was_credit && !act) begin
                m_idle++;
                if (m_idle == T_OUT) start_refund();
            end
        end else if (m_mode == M_DISP) begin
            e_rej = live; e_nack = sv;
            if (da) begin
                m_credit -= price[m_disp_id];
                if (m_credit > 0) start_refund(); else m_mode = M_IDLE;
            end
        end else begin
            e_rej = live; e_nack = sv;
            if (m_req && ca) begin
                m_req = 0;
                m_credit -= coin_val(exp_q.pop_front());
                if (exp_q.size() == 0) m_mode = M_IDLE; else m_pending = 1;
            end else if (m_pending) begin
                m_req = 1; m_coin = exp_q[0]; m_pending = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".coin_accept"}, coin_accept, e_acc);
        chk({tag, ".coin_reject"}, coin_reject, e_rej);
        chk({tag, ".sel_ack"},     sel_ack,     e_ack);
        chk({tag, ".sel_nack"},    sel_nack,    e_nack);
        chk({tag, ".credit"},      credit,      m_credit);
        chk({tag, ".disp_req"},    disp_req,    m_mode == M_DISP);
        chk({tag, ".busy"},        busy,        m_mode == M_DISP || m_mode == M_CHANGE);
        chk({tag, ".chg_req"},     chg_req,     m_req);
        if (m_mode == M_DISP) chk({tag, ".disp_id"}, disp_id, m_disp_id);
        if (m_req)            chk({tag, ".chg_coin"}, chg_coin, m_coin);
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1: drive, advance model, cross the edge, sample at posedge+1.
    task automatic step(input string tag, input bit cv, input logic [1:0] cc, input bit sv,
                        input logic [1:0] sid, input bit cn, input bit da, input bit ca);
        coin_valid = cv; coin_code = cc; sel_valid = sv; sel_id = sid;
        cancel = cn; disp_ack = da; chg_ack = ca;
        model_step(cv, cc, sv, sid, cn, da, ca);
        @(posedge clk); #1;
        coin_valid = 0; coin_code = 0; sel_valid = 0; sel_id = 0;
        cancel = 0; disp_ack = 0; chg_ack = 0;
        check_outputs(tag);
    endtask

    task automatic coin(input string tag, input logic [1:0] cc);
        step(tag, 1, cc, 0, 0, 0, 0, 0);
    endtask

    task automatic sel(input string tag, input logic [1:0] sid);
        step(tag, 0, 0, 1, sid, 0, 0, 0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Ack every change request immediately; bounded.
    task automatic serve_change(input string tag);
        int n;
        n = 0;
        while (m_mode != M_IDLE && n < 100) begin
            step(tag, 0, 0, 0, 0, 0, 0, m_req);
            n++;
        end
        chk({tag, ".drained_busy"}, busy, 0);
        chk({tag, ".drained_credit"}, credit, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; coin_valid = 0; coin_code = 0; sel_valid = 0; sel_id = 0;
        cancel = 0; disp_ack = 0; chg_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {coin_accept, coin_reject, sel_ack, sel_nack, disp_req,
                              disp_id, chg_req, chg_coin, credit, busy}, 0);
        reset = 0;
        idle("reset.idle", 2);

        // 10 + 5 tk, select product 1, dispense, no change
        coin("t1.c10", 2'b10);
        coin("t1.c5", 2'b01);
        chk("t1.credit3", credit, 3);
        sel("t1.sel1", 2'd1);
        chk("t1.sel_ack", sel_ack, 1);
        chk("t1.disp_id", disp_id, 1);
        idle("t1.wait", 2);
        step("t1.dack", 0, 0, 0, 0, 0, 1, 0);
        chk("t1.credit0", credit, 0);
        idle("t1.nochg", 3);
        chk("t1.no_chg_req", chg_req, 0);

        // 20 + 10 tk, select 0, change 10 + 10; spurious ack in the gap
        coin("t2.c20", 2'b11);
        coin("t2.c10", 2'b10);
        sel("t2.sel0", 2'd0);
        step("t2.dack", 0, 0, 0, 0, 0, 1, 0);
        chk("t2.credit4", credit, 4);
        idle("t2.rise", 1);
        chk("t2.req1", chg_req, 1);
        chk("t2.coin1", chg_coin, 2'b10);
        step("t2.ack1", 0, 0, 0, 0, 0, 0, 1);
        chk("t2.credit2", credit, 2);
        step("t2.gap_ack", 0, 0, 0, 0, 0, 0, 1);
        serve_change("t2.drain");

        // underfunded select, coin 00 ignored, then cancel
        coin("t3.c5", 2'b01);
        sel("t3.sel2", 2'd2);
        chk("t3.nack", sel_nack, 1);
        chk("t3.credit1", credit, 1);
        coin("t3.c00", 2'b00);
        step("t3.cancel", 0, 0, 0, 0, 1, 0, 0);
        serve_change("t3.drain");

        // credit 10, a 20 tk coin overflows
        coin("t4.a", 2'b11); coin("t4.b", 2'b11); coin("t4.c", 2'b10);
        coin("t4.over", 2'b11);
        chk("t4.reject", coin_reject, 1);
        chk("t4.credit10", credit, 10);
        coin("t4.fit5", 2'b01);
        coin("t4.fit5b", 2'b01);
        coin("t4.over5", 2'b01);
        step("t4.cancel", 0, 0, 0, 0, 1, 0, 0);
        serve_change("t4.drain");

        // credit 3, cancel -> 10 then 5; then timeout refund
        coin("t5.c10", 2'b10); coin("t5.c5", 2'b01);
        step("t5.cancel", 0, 0, 0, 0, 1, 0, 0);
        serve_change("t5.drain");
        coin("t5b.c10", 2'b10); coin("t5b.c5", 2'b01);
        idle("t5b.wait", T_OUT - 1);
        chk("t5b.not_yet", busy, 0);
        idle("t5b.expire", 1);
        chk("t5b.busy", busy, 1);
        serve_change("t5b.drain");

        // coin + select same cycle, coin + cancel same cycle
        coin("t6.c5", 2'b01);
        step("t6.both", 1, 2'b01, 1, 2'd0, 0, 0, 0);
        chk("t6.accept", coin_accept, 1);
        chk("t6.nack", sel_nack, 1);
        chk("t6.credit2", credit, 2);
        step("t6.coin_cancel", 1, 2'b10, 0, 0, 1, 0, 0);
        chk("t6.credit4", credit, 4);
        idle("t6.rise", 1);
        chk("t6.req", chg_req, 1);

        // reset mid-change: outputs drop within the same cycle
        #2 reset = 1;
        #1;
        chk("t7.reset_outputs", {coin_accept, coin_reject, sel_ack, sel_nack, disp_req,
                                 disp_id, chg_req, chg_coin, credit, busy}, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        idle("t7.after", 2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit cv, sv, cn, da, ca;
            logic [1:0] cc, sid;
            cv  = ($urandom_range(0, 99) < 25);
            cc  = 2'($urandom_range(0, 3));
            sv  = ($urandom_range(0, 99) < 12);
            sid = 2'($urandom_range(0, 3));
            cn  = !sv && ($urandom_range(0, 99) < 3);
            da  = (m_mode == M_DISP) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            ca  = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
            step("rnd", cv, cc, sv, sid, cn, da, ca);
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
